// File: rtl/lux_pkg.sv
// Shared types and default constants for the lux sampling/averaging block.
package lux_pkg;

    localparam int LUX_DATA_W        = 8;
    localparam int LUX_LOG2_SAMPLES  = 3;
    localparam int LUX_SAMPLE_PERIOD = 50000;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        REQ,
        DONE
    } lux_state_t;

    // A period of 1 still needs a 1-bit counter to hold the value 0.
    function automatic int timer_width(input int period);
        return (period > 1) ? $clog2(period) : 1;
    endfunction

endpackage

// File: rtl/lux_filter_sample_timer.sv
// Loadable down-counter that paces sensor requests; zero flags expiry.
module sample_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             en,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    // Load wins over decrement; the counter parks at zero instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/lux_filter.sv
// Periodic sensor sampler producing a truncated mean over 2^LOG2_SAMPLES readings.
// Optional output freeze via the hold port when LUX_FILTER_HOLD_EN is defined.
module lux_filter
    import lux_pkg::*;
#(
    parameter int DATA_W        = LUX_DATA_W,
    parameter int LOG2_SAMPLES  = LUX_LOG2_SAMPLES,
    parameter int SAMPLE_PERIOD = LUX_SAMPLE_PERIOD
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    output logic              sns_valid,
    input  logic              sns_ready,
    input  logic [DATA_W-1:0] sns_data,
    output logic [DATA_W-1:0] lux_avg,
    output logic              lux_avg_valid,
    output logic              overrange
`ifdef LUX_FILTER_HOLD_EN
    ,
    input  logic              hold
`endif
);

    localparam int ACC_W   = DATA_W + LOG2_SAMPLES;
    localparam int CNT_W   = LOG2_SAMPLES + 1;
    localparam int TIMER_W = timer_width(SAMPLE_PERIOD);

    localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'((1 << LOG2_SAMPLES) - 1);
    localparam logic [TIMER_W-1:0] RELOAD   = TIMER_W'(SAMPLE_PERIOD - 1);
    localparam logic [DATA_W-1:0]  ALL_ONES = '1;

    lux_state_t        state;
    lux_state_t        next_state;
    logic              timer_load;
    logic              timer_en;
    logic              timer_zero;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  sum;
    logic [CNT_W-1:0]  cnt;
    logic              sticky;
    logic              sample_full;
    logic              accept;
    logic              last_sample;
    logic              hold_active;

`ifdef LUX_FILTER_HOLD_EN
    assign hold_active = hold;
`else
    assign hold_active = 1'b0;
`endif

    sample_timer #(
        .WIDTH(TIMER_W)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .load      (timer_load),
        .load_value(RELOAD),
        .en        (timer_en),
        .zero      (timer_zero)
    );

    // A reading returned after enable drops is not accepted into the window.
    assign accept      = (state == REQ) && sns_ready && enable;
    assign last_sample = accept && (cnt == LAST_CNT);
    assign sum         = acc + ACC_W'(sns_data);
    assign sample_full = (sns_data == ALL_ONES);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        timer_load = 1'b0;
        timer_en   = 1'b0;
        sns_valid  = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    timer_load = 1'b1;
                    next_state = WAIT;
                end
            end
            WAIT: begin
                if (!enable) begin
                    next_state = IDLE;
                end else begin
                    timer_en = 1'b1;
                    if (timer_zero) begin
                        next_state = REQ;
                    end
                end
            end
            REQ: begin
                // An SPI transfer in flight is always allowed to finish.
                sns_valid = 1'b1;
                if (sns_ready) begin
                    if (!enable) begin
                        next_state = IDLE;
                    end else if (cnt == LAST_CNT) begin
                        next_state = DONE;
                    end else begin
                        timer_load = 1'b1;
                        next_state = WAIT;
                    end
                end
            end
            DONE: begin
                if (!enable) begin
                    next_state = IDLE;
                end else begin
                    timer_load = 1'b1;
                    next_state = WAIT;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Outputs are captured on the final reading so they are already visible
    // during the DONE cycle, together with the one-cycle valid pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc           <= '0;
            cnt           <= '0;
            sticky        <= 1'b0;
            lux_avg       <= '0;
            overrange     <= 1'b0;
            lux_avg_valid <= 1'b0;
        end else begin
            lux_avg_valid <= 1'b0;
            if ((state == IDLE) || (state == DONE)) begin
                acc    <= '0;
                cnt    <= '0;
                sticky <= 1'b0;
            end else if (accept) begin
                acc    <= sum;
                cnt    <= cnt + 1'b1;
                sticky <= sticky | sample_full;
                if (last_sample && !hold_active) begin
                    lux_avg       <= sum[ACC_W-1:LOG2_SAMPLES];
                    overrange     <= sticky | sample_full;
                    lux_avg_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_lux_filter.sv
// Self-checking bench for lux_filter with a queue-based window-mean reference model.
// Exercises the hold feature as well when LUX_FILTER_HOLD_EN is defined.
module tb_lux_filter;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       sns_valid;
    logic       sns_ready;
    logic [7:0] sns_data;
    logic [7:0] lux_avg;
    logic       lux_avg_valid;
    logic       overrange;
    logic       hold;

    int checks = 0;
    int errors = 0;
    int expAvg = 0;
    int expOvr = 0;
    int window[$];

    always #5 clk = ~clk;

    lux_filter #(
        .DATA_W       (8),
        .LOG2_SAMPLES (2),
        .SAMPLE_PERIOD(4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .sns_valid    (sns_valid),
        .sns_ready    (sns_ready),
        .sns_data     (sns_data),
        .lux_avg      (lux_avg),
        .lux_avg_valid(lux_avg_valid),
        .overrange    (overrange)
`ifdef LUX_FILTER_HOLD_EN
        ,
        .hold         (hold)
`endif
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Reference: collect accepted readings; every 4th closes a window whose
    // floor mean and any-255 flag become the expected outputs (unless held).
    task automatic modelAccept(input logic [7:0] d, output bit pulse);
        int sum;
        int anyFull;
        pulse = 1'b0;
        if (!enable) begin
            window.delete();
            return;
        end
        window.push_back(int'(d));
        if (window.size() == 4) begin
            sum = 0;
            anyFull = 0;
            foreach (window[i]) begin
                sum += window[i];
                if (window[i] == 255) anyFull = 1;
            end
            if (!hold) begin
                expAvg = sum / 4;
                expOvr = anyFull;
                pulse  = 1'b1;
            end
            window.delete();
        end
    endtask

    // Serves one sensor request: checks request spacing, answers after
    // 'latency' cycles, optionally drops enable mid-request, then checks outputs.
    task automatic applyStimulus(input logic [7:0] d, input int latency, input int dropAt);
        int n;
        int gap;
        bit pulse;
        n = 0;
        gap = (window.size() == 0) ? 5 : 4;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) checkOutput("valid_one_cycle", lux_avg_valid, 0);
            if (n == 2) begin
                sns_ready = 1'b1;
                sns_data  = 8'hFF;
            end
            if (n == 3) sns_ready = 1'b0;
        end while (!sns_valid && n < 100);
        sns_ready = 1'b0;
        checkOutput("req_gap", n, gap);
        for (int i = 1; i < latency; i++) begin
            @(negedge clk);
            if (i == dropAt) enable = 1'b0;
            checkOutput("valid_held", sns_valid, 1);
        end
        @(negedge clk);
        sns_ready = 1'b1;
        sns_data  = d;
        modelAccept(d, pulse);
        @(negedge clk);
        sns_ready = 1'b0;
        sns_data  = 8'($urandom);
        checkOutput("valid_fall", sns_valid, 0);
        checkOutput("avg_pulse", lux_avg_valid, 32'(pulse));
        checkOutput("lux_avg", lux_avg, expAvg);
        checkOutput("overrange", overrange, expOvr);
    endtask

    task automatic runWindow(input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] c, input logic [7:0] d);
        applyStimulus(a, 3, -1);
        applyStimulus(b, 3, -1);
        applyStimulus(c, 3, -1);
        applyStimulus(d, 3, -1);
    endtask

    initial begin
        int n;
        bit sawValid;
        logic [7:0] s;

        rst       = 1'b1;
        enable    = 1'b0;
        sns_ready = 1'b0;
        sns_data  = 8'h00;
        hold      = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_sns_valid", sns_valid, 0);
        checkOutput("rst_lux_avg", lux_avg, 0);
        checkOutput("rst_avg_valid", lux_avg_valid, 0);
        checkOutput("rst_overrange", overrange, 0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("idle_no_req", sns_valid, 0);
        enable = 1'b1;

        runWindow(8'd10, 8'd20, 8'd30, 8'd40);
        checkOutput("mean_25", lux_avg, 25);

`ifdef LUX_FILTER_HOLD_EN
        hold = 1'b1;
        runWindow(8'd100, 8'd100, 8'd100, 8'd100);
        checkOutput("hold_frozen", lux_avg, 25);
        hold = 1'b0;
        runWindow(8'd60, 8'd60, 8'd60, 8'd60);
        checkOutput("after_hold", lux_avg, 60);
`endif

        runWindow(8'd1, 8'd2, 8'd2, 8'd2);
        checkOutput("floor_mean", lux_avg, 1);
        runWindow(8'd3, 8'd3, 8'd3, 8'd3);
        checkOutput("mean_3", lux_avg, 3);

        applyStimulus(8'd50, 3, -1);
        applyStimulus(8'd77, 10, 2);
        sawValid = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (sns_valid) sawValid = 1'b1;
        end
        checkOutput("disabled_no_req", sawValid, 0);
        checkOutput("disabled_avg_kept", lux_avg, 3);
        enable = 1'b1;
        runWindow(8'd8, 8'd8, 8'd8, 8'd8);
        checkOutput("fresh_window", lux_avg, 8);

        runWindow(8'd255, 8'd255, 8'd255, 8'd255);
        checkOutput("full_scale_ovr", overrange, 1);
        runWindow(8'd0, 8'd0, 8'd0, 8'd0);
        checkOutput("zero_ovr_clear", overrange, 0);

        for (int w = 0; w < 6; w++) begin
            for (int k = 0; k < 4; k++) begin
                s = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
                applyStimulus(s, int'($urandom_range(1, 5)), -1);
            end
        end

        applyStimulus(8'd200, 3, -1);
        applyStimulus(8'd200, 3, -1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sns_valid && n < 20);
        checkOutput("pre_rst_req", sns_valid, 1);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrst_sns_valid", sns_valid, 0);
        checkOutput("midrst_lux_avg", lux_avg, 0);
        checkOutput("midrst_avg_valid", lux_avg_valid, 0);
        checkOutput("midrst_overrange", overrange, 0);
        window.delete();
        expAvg = 0;
        expOvr = 0;
        rst = 1'b0;
        runWindow(8'd9, 8'd9, 8'd9, 8'd9);
        checkOutput("post_rst_mean", lux_avg, 9);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
